// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression-block sequencer: accepts 16 message words, steps the
// round index that addresses the K ROM, and drives the datapath strobes.
// Optional feature macro: SHA256_ABORT_EN (adds i_abort to cancel a block).
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for i_start; o_done shows here for one cycle
// S_LOAD  | taking message words W0..W15, stalls without i_msg_valid
// S_ROUND | rounds WORDS..ROUNDS-1, W from the schedule expander
// S_FINAL | one cycle of H += working regs
module sha256_round_ctrl #(
  parameter int ROUNDS = 64,
  parameter int WORDS  = 16,
  parameter int CNT_W  = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_init,
  input  logic             i_msg_valid,
`ifdef SHA256_ABORT_EN
  input  logic             i_abort,
`endif
  output logic             o_msg_ready,
  output logic [CNT_W-1:0] o_coef_num,
  output logic             o_round_en,
  output logic             o_w_sel,
  output logic             o_load_iv,
  output logic             o_load_chain,
  output logic             o_final_add,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_done;
  logic             w_abort;

`ifdef SHA256_ABORT_EN
  // Abort only matters while words or rounds are in flight.
  assign w_abort = i_abort & ((r_state == S_LOAD) | (r_state == S_ROUND));
`else
  assign w_abort = 1'b0;
`endif

  assign o_coef_num = r_cnt;
  assign o_done     = r_done;

  // State, round counter and the done flag that marks the IDLE cycle after FINAL.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= (r_state == S_FINAL);
    end
  end

  // Next-state, counter update and all datapath strobes.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    o_msg_ready  = 1'b0;
    o_round_en   = 1'b0;
    o_w_sel      = 1'b0;
    o_load_iv    = 1'b0;
    o_load_chain = 1'b0;
    o_final_add  = 1'b0;
    o_busy       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        o_load_iv    = i_start & i_init;
        o_load_chain = i_start & ~i_init;
        if (i_start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        o_busy = 1'b1;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          o_msg_ready = 1'b1;
          o_round_en  = i_msg_valid;
          if (i_msg_valid) begin
            if (r_cnt == CNT_W'(WORDS - 1)) begin
              w_state_nxt = S_ROUND;
              w_cnt_nxt   = CNT_W'(WORDS);
            end else begin
              w_cnt_nxt = r_cnt + 1'b1;
            end
          end
        end
      end
      S_ROUND: begin
        o_busy  = 1'b1;
        o_w_sel = 1'b1;
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          o_round_en = 1'b1;
          // Counter parks at the last round so the ROM address never wraps.
          if (r_cnt == CNT_W'(ROUNDS - 1)) begin
            w_state_nxt = S_FINAL;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_FINAL: begin
        o_busy      = 1'b1;
        o_final_add = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Scoreboard bench for sha256_round_ctrl: stimulus pushes expected strobe
// events, the monitor pops and compares on each DUT output event.
// Define SHA256_ABORT_EN to also exercise the abort path.
module tb_sha256_round_ctrl;

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_init;
  logic       i_msg_valid;
  logic       i_abort;
  logic       o_msg_ready;
  logic [6:0] o_coef_num;
  logic       o_round_en;
  logic       o_w_sel;
  logic       o_load_iv;
  logic       o_load_chain;
  logic       o_final_add;
  logic       o_busy;
  logic       o_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    string       name;
    logic [31:0] act;
    logic [31:0] exp;
  } chk_t;

  logic [8:0] q_round[$];  // {coef_num, w_sel, msg_ready}
  logic [1:0] q_load[$];   // {load_iv, load_chain}
  int         q_fin[$];    // cycle of o_final_add
  int         q_done[$];   // cycle of o_done
  chk_t       q_chk[$];    // direct checks posted by stimulus

  sha256_round_ctrl dut (
    .i_clk        (clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_init       (i_init),
    .i_msg_valid  (i_msg_valid),
`ifdef SHA256_ABORT_EN
    .i_abort      (i_abort),
`endif
    .o_msg_ready  (o_msg_ready),
    .o_coef_num   (o_coef_num),
    .o_round_en   (o_round_en),
    .o_w_sel      (o_w_sel),
    .o_load_iv    (o_load_iv),
    .o_load_chain (o_load_chain),
    .o_final_add  (o_final_add),
    .o_busy       (o_busy),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every DUT event against the scoreboard queues.
  always @(negedge clk) begin
    logic [8:0] exp_r;
    logic [1:0] exp_l;
    int         exp_c;
    chk_t       c;
    if (o_round_en) begin
      checks++;
      if (q_round.size() == 0) begin
        errors++;
        $display("FAIL round_unexpected cyc=%0d got coef=%0d", cyc, o_coef_num);
      end else begin
        exp_r = q_round.pop_front();
        if ({o_coef_num, o_w_sel, o_msg_ready} !== exp_r) begin
          errors++;
          $display("FAIL round cyc=%0d got coef=%0d wsel=%0b rdy=%0b want coef=%0d wsel=%0b rdy=%0b",
                   cyc, o_coef_num, o_w_sel, o_msg_ready, exp_r[8:2], exp_r[1], exp_r[0]);
        end
      end
    end
    if (o_load_iv || o_load_chain) begin
      checks++;
      if (q_load.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected cyc=%0d got iv=%0b chain=%0b", cyc, o_load_iv, o_load_chain);
      end else begin
        exp_l = q_load.pop_front();
        if ({o_load_iv, o_load_chain} !== exp_l) begin
          errors++;
          $display("FAIL load cyc=%0d got %b want %b", cyc, {o_load_iv, o_load_chain}, exp_l);
        end
      end
    end
    if (o_final_add) begin
      checks++;
      if (q_fin.size() == 0) begin
        errors++;
        $display("FAIL final_unexpected cyc=%0d", cyc);
      end else begin
        exp_c = q_fin.pop_front();
        if (cyc != exp_c) begin
          errors++;
          $display("FAIL final_cycle got %0d want %0d", cyc, exp_c);
        end
      end
    end
    if (o_done) begin
      checks++;
      if (q_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d", cyc);
      end else begin
        exp_c = q_done.pop_front();
        if (cyc != exp_c) begin
          errors++;
          $display("FAIL done_cycle got %0d want %0d", cyc, exp_c);
        end
      end
    end
    while (q_chk.size() != 0) begin
      c = q_chk.pop_front();
      checks++;
      if (c.act !== c.exp) begin
        errors++;
        $display("FAIL %s got %0h want %0h", c.name, c.act, c.exp);
      end
    end
  end

  task automatic post(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    q_chk.push_back(c);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [31:0] all_outs();
    return {17'd0, o_msg_ready, o_round_en, o_w_sel, o_load_iv, o_load_chain,
            o_final_add, o_busy, o_done, o_coef_num};
  endfunction

  // One block starting in the current cycle; optional stray start, reset or abort.
  // Returns positioned in the o_done cycle (or just after reset/abort).
  task automatic run_block(input bit init, input bit gap, input int pulse_at,
                           input int rst_at, input int abort_at);
    int t0;
    int extra;
    t0    = cyc;
    extra = gap ? 16 : 0;
    i_start = 1'b1;
    i_init  = init;
    q_load.push_back({init, ~init});
    step();
    i_start = 1'b0;
    i_init  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (gap) begin
        i_msg_valid = 1'b0;
        step();
      end
      if (k == abort_at) begin
        i_msg_valid = 1'b1;
        i_abort     = 1'b1;
        #1;
        post("abort_strobes", {30'd0, o_round_en, o_msg_ready}, 32'd0);
        step();
        i_abort     = 1'b0;
        i_msg_valid = 1'b0;
        post("abort_busy", {31'd0, o_busy}, 32'd0);
        post("abort_cnt", {25'd0, o_coef_num}, 32'd0);
        return;
      end
      i_msg_valid = 1'b1;
      q_round.push_back({7'(k), 1'b0, 1'b1});
      step();
    end
    i_msg_valid = 1'b0;
    for (int r = 16; r < 64; r++) begin
      if (r == rst_at) begin
        i_rst_n = 1'b0;
        #1;
        post("midblock_reset_outs", all_outs(), 32'd0);
        idle(2);
        i_rst_n = 1'b1;
        step();
        return;
      end
      if (r == pulse_at) begin
        i_start = 1'b1;
        i_init  = 1'b1;
      end
      q_round.push_back({7'(r), 1'b1, 1'b0});
      step();
      i_start = 1'b0;
      i_init  = 1'b0;
    end
    q_fin.push_back(t0 + 65 + extra);
    q_done.push_back(t0 + 66 + extra);
    step();
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_start     = 1'b0;
    i_init      = 1'b0;
    i_msg_valid = 1'b0;
    i_abort     = 1'b0;
    idle(3);
    post("reset_outs", all_outs(), 32'd0);
    i_rst_n = 1'b1;
    step();
    post("idle_ready", {31'd0, o_msg_ready}, 32'd0);

    // Case 1: single block, IV load, valid held high.
    run_block(1'b1, 1'b0, -1, -1, -1);
    idle(2);
    // Case 2: valid toggling during LOAD.
    run_block(1'b1, 1'b1, -1, -1, -1);
    idle(1);
    // Case 3: two-block chain, second start in the o_done cycle.
    run_block(1'b1, 1'b0, -1, -1, -1);
    run_block(1'b0, 1'b0, -1, -1, -1);
    idle(2);
    // Case 4: stray start at round 30.
    run_block(1'b1, 1'b0, 30, -1, -1);
    idle(2);
    // Case 5: reset at round 40, then a normal block.
    run_block(1'b1, 1'b0, -1, 40, -1);
    run_block(1'b1, 1'b0, -1, -1, -1);
    idle(2);
`ifdef SHA256_ABORT_EN
    // Case 6: abort at word 5, then a normal block.
    run_block(1'b1, 1'b0, -1, -1, 5);
    idle(1);
    run_block(1'b1, 1'b0, -1, -1, -1);
    idle(2);
`endif
    idle(5);
    post("round_q_drained", q_round.size(), 32'd0);
    post("load_q_drained", q_load.size(), 32'd0);
    post("final_q_drained", q_fin.size(), 32'd0);
    post("done_q_drained", q_done.size(), 32'd0);
    post("end_busy", {31'd0, o_busy}, 32'd0);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
